// File: rtl/riscv_isa_pkg.sv
// Shared RV32 encoding constants: opcodes, forced funct3 values, request classes
// and the immediate ranges accepted by the I/S and B formats.
package riscv_isa_pkg;

    localparam logic [6:0] OP_RT  = 7'b0110011;
    localparam logic [6:0] OP_IT  = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_IT  = 3'd1,
        CLS_LW  = 3'd2,
        CLS_SW  = 3'd3,
        CLS_BEQ = 3'd4
    } instr_class_e;

    // Sign-bit positions of the 12-bit I/S and 13-bit B immediates.
    localparam int IMM_I_SIGN = 11;
    localparam int IMM_B_SIGN = 12;

    localparam int IMM_I_MIN = -2048;
    localparam int IMM_I_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;

endpackage

// File: rtl/imm_scatter.sv
// Range-checks a signed immediate for its class and places its bits where the
// RV32 format expects them; every other bit of imm_bits is zero.
module imm_scatter
    import riscv_isa_pkg::*;
#(
    parameter int IMMSIZE = 64
) (
    input  logic [2:0]                cls,
    input  logic signed [IMMSIZE-1:0] imm,
    output logic [31:0]               imm_bits,
    output logic                      legal
);

    logic i_fits;
    logic b_fits;

    // A value fits when every bit above the format's sign bit copies it.
    assign i_fits = (&imm[IMMSIZE-1:IMM_I_SIGN]) || !(|imm[IMMSIZE-1:IMM_I_SIGN]);
    assign b_fits = ((&imm[IMMSIZE-1:IMM_B_SIGN]) || !(|imm[IMMSIZE-1:IMM_B_SIGN]))
                    && !imm[0];

    always_comb begin
        imm_bits = '0;
        legal    = 1'b0;
        case (cls)
            CLS_R: begin
                legal = 1'b1;
            end
            CLS_IT, CLS_LW: begin
                imm_bits[31:20] = imm[11:0];
                legal           = i_fits;
            end
            CLS_SW: begin
                imm_bits[31:25] = imm[11:5];
                imm_bits[11:7]  = imm[4:0];
                legal           = i_fits;
            end
            CLS_BEQ: begin
                imm_bits[31]    = imm[12];
                imm_bits[30:25] = imm[10:5];
                imm_bits[11:8]  = imm[4:1];
                imm_bits[7]     = imm[11];
                legal           = b_fits;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/immediate_generator.sv
// Immediate decode path: extracts the sign-extended immediate from an RV32
// IT/LW/SW/BEQ word; other opcodes yield zero.
module immediate_generator
    import riscv_isa_pkg::*;
#(
    parameter int IMMSIZE = 64
) (
    input  logic [31:0]               instr,
    output logic signed [IMMSIZE-1:0] imm
);

    logic unused_fields;
    assign unused_fields = ^instr[19:12];

    always_comb begin
        imm = '0;
        case (instr[6:0])
            OP_IT, OP_LW: imm = {{(IMMSIZE-12){instr[31]}}, instr[31:20]};
            OP_SW:        imm = {{(IMMSIZE-12){instr[31]}}, instr[31:25], instr[11:7]};
            OP_BEQ:       imm = {{(IMMSIZE-13){instr[31]}}, instr[31], instr[7],
                                 instr[30:25], instr[11:8], 1'b0};
            default:      imm = '0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage RV32 instruction encoder streaming packed words with byte addresses
// to an instruction-memory write port; illegal requests are counted and dropped.
module instr_encoder
    import riscv_isa_pkg::*;
#(
    parameter int INSTRSIZE = 32,
    parameter int IMMSIZE   = 64,
    parameter int ADDRSIZE  = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                in_class,
    input  logic [4:0]                in_rd,
    input  logic [4:0]                in_rs1,
    input  logic [4:0]                in_rs2,
    input  logic [2:0]                in_funct3,
    input  logic [6:0]                in_funct7,
    input  logic signed [IMMSIZE-1:0] in_imm,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [ADDRSIZE-1:0]       mem_addr,
    output logic [INSTRSIZE-1:0]      mem_wdata,
    input  logic                      addr_load,
    input  logic [ADDRSIZE-1:0]       addr_base,
    output logic                      err,
    input  logic                      err_clr,
    output logic [7:0]                err_count
);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic                      rdy;
    logic                      vld_p1;
    logic [2:0]                cls_p1;
    logic [4:0]                rd_p1;
    logic [4:0]                rs1_p1;
    logic [4:0]                rs2_p1;
    logic [2:0]                f3_p1;
    logic [6:0]                f7_p1;
    logic signed [IMMSIZE-1:0] imm_p1;
    logic                      vld_p2;
    logic [INSTRSIZE-1:0]      word_p2;
    logic [ADDRSIZE-1:0]       addr_p2;
    logic [ADDRSIZE-1:0]       ptr;

    logic                      s2_adv;
    logic                      accept;
    logic                      enter;
    logic                      drop;
    logic                      legal;
    logic [31:0]               imm_bits;
    logic [INSTRSIZE-1:0]      word_p1;

    assign s2_adv   = !vld_p2 || mem_ready;
    assign in_ready = rdy && (!vld_p1 || s2_adv);
    assign accept   = in_valid && in_ready;
    assign enter    = vld_p1 && s2_adv && legal;
    assign drop     = vld_p1 && s2_adv && !legal;

    // ---- stage 1: request register, legality check, word assembly ----
    always_ff @(posedge clk) begin
        if (accept) begin
            cls_p1 <= in_class;
            rd_p1  <= in_rd;
            rs1_p1 <= in_rs1;
            rs2_p1 <= in_rs2;
            f3_p1  <= in_funct3;
            f7_p1  <= in_funct7;
            imm_p1 <= in_imm;
        end
    end

    imm_scatter #(.IMMSIZE(IMMSIZE)) u_scatter (
        .cls      (cls_p1),
        .imm      (imm_p1),
        .imm_bits (imm_bits),
        .legal    (legal)
    );

    always_comb begin
        word_p1 = '0;
        case (cls_p1)
            CLS_R:   word_p1 = {f7_p1, rs2_p1, rs1_p1, f3_p1, rd_p1, OP_RT};
            CLS_IT:  word_p1 = imm_bits | {12'd0, rs1_p1, f3_p1, rd_p1, OP_IT};
            CLS_LW:  word_p1 = imm_bits | {12'd0, rs1_p1, F3_LW, rd_p1, OP_LW};
            CLS_SW:  word_p1 = imm_bits | {7'd0, rs2_p1, rs1_p1, F3_SW, 5'd0, OP_SW};
            CLS_BEQ: word_p1 = imm_bits | {7'd0, rs2_p1, rs1_p1, F3_BEQ, 5'd0, OP_BEQ};
            default: word_p1 = '0;
        endcase
    end

    // ---- stage 2: encoded word, write pointer and error bookkeeping ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy       <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            word_p2   <= '0;
            addr_p2   <= '0;
            ptr       <= '0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            rdy <= 1'b1;
            if (in_ready) begin
                vld_p1 <= accept;
            end
            if (s2_adv) begin
                vld_p2 <= enter;
            end
            if (enter) begin
                word_p2 <= word_p1;
                addr_p2 <= ptr;
            end
            // A load overrides the increment; the entering word already took ptr.
            if (addr_load) begin
                ptr <= addr_base & ~ADDRSIZE'(3);
            end else if (enter) begin
                ptr <= ptr + ADDRSIZE'(4);
            end
            if (drop) begin
                err       <= 1'b1;
                err_count <= sat_inc(err_clr ? 8'd0 : err_count);
            end else if (err_clr) begin
                err       <= 1'b0;
                err_count <= '0;
            end
        end
    end

    assign mem_valid = vld_p2;
    assign mem_addr  = addr_p2;
    assign mem_wdata = word_p2;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: vector table plus hand-written sequences for
// back-pressure, pointer control, error saturation/clear and mid-stream reset.
module tb_instr_encoder;
    import riscv_isa_pkg::*;

    typedef struct {
        logic [2:0]         cls;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [2:0]         f3;
        logic [6:0]         f7;
        logic signed [63:0] imm;
        logic               legal;
        logic [31:0]        word;
    } vec_t;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_class;
    logic [4:0]         in_rd;
    logic [4:0]         in_rs1;
    logic [4:0]         in_rs2;
    logic [2:0]         in_funct3;
    logic [6:0]         in_funct7;
    logic signed [63:0] in_imm;
    logic               mem_valid;
    logic               mem_ready;
    logic [11:0]        mem_addr;
    logic [31:0]        mem_wdata;
    logic               addr_load;
    logic [11:0]        addr_base;
    logic               err;
    logic               err_clr;
    logic [7:0]         err_count;
    logic signed [63:0] rt_imm;

    int nerr = 0;
    int nchk = 0;
    logic accepted;
    logic [11:0]        wq_addr[$];
    logic [31:0]        wq_data[$];
    logic signed [63:0] wq_imm[$];
    vec_t vecs[16];

    instr_encoder #(.INSTRSIZE(32), .IMMSIZE(64), .ADDRSIZE(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_class  (in_class),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .addr_load (addr_load),
        .addr_base (addr_base),
        .err       (err),
        .err_clr   (err_clr),
        .err_count (err_count)
    );

    immediate_generator #(.IMMSIZE(64)) u_igen (
        .instr (mem_wdata),
        .imm   (rt_imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Looks at the settled pre-edge values and logs any handshake about to happen.
    task automatic obs();
        #1;
        accepted = in_valid && in_ready;
        if (mem_valid && mem_ready) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_wdata);
            wq_imm.push_back(rt_imm);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            obs();
            @(negedge clk);
        end
    endtask

    task automatic drive(input vec_t v);
        in_class  = v.cls;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_funct3 = v.f3;
        in_funct7 = v.f7;
        in_imm    = v.imm;
    endtask

    function automatic vec_t mk(input logic [2:0] c, input int rd, input int rs1,
                                input int rs2, input int f3, input int f7,
                                input longint imm, input logic legal, input logic [31:0] w);
        vec_t v;
        v.cls = c;          v.rd = 5'(rd);  v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
        v.f3 = 3'(f3);      v.f7 = 7'(f7);  v.imm = imm;     v.legal = legal;
        v.word = w;
        return v;
    endfunction

    function automatic logic [31:0] exp_r(input int rd, input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'b0110011};
    endfunction

    task automatic send_one(input vec_t v, input logic [11:0] eaddr, input string name);
        logic got;
        got = 1'b0;
        wq_addr.delete(); wq_data.delete(); wq_imm.delete();
        drive(v);
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            obs();
            if (accepted) got = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk({name, "_accept"}, 64'(got), 64'd1);
        idle(4);
        if (v.legal) begin
            chk({name, "_nwords"}, 64'(wq_data.size()), 64'd1);
            if (wq_data.size() > 0) begin
                chk({name, "_wdata"}, 64'(wq_data[0]), 64'(v.word));
                chk({name, "_addr"}, 64'(wq_addr[0]), 64'(eaddr));
                if (v.cls != CLS_R) chk({name, "_roundtrip"}, wq_imm[0], v.imm);
            end
        end else begin
            chk({name, "_dropped"}, 64'(wq_data.size()), 64'd0);
        end
    endtask

    initial begin
        logic [11:0] exp_ptr;
        int          n_illegal;
        int          k;
        logic [31:0] hold_data;
        logic [11:0] hold_addr;

        vecs[0]  = mk(CLS_IT, 5, 6, 0, 0, 0, -1, 1'b1, 32'hFFF30293);
        vecs[1]  = mk(CLS_SW, 0, 2, 8, 0, 0, 12, 1'b1, 32'h00812623);
        vecs[2]  = mk(CLS_BEQ, 0, 1, 2, 0, 0, -8, 1'b1, 32'hFE208CE3);
        vecs[3]  = mk(CLS_R, 3, 1, 2, 0, 7'h20, 0, 1'b1, 32'h402081B3);
        vecs[4]  = mk(CLS_LW, 10, 2, 0, 7, 0, 2047, 1'b1, 32'h7FF12503);
        vecs[5]  = mk(CLS_BEQ, 0, 1, 2, 0, 0, 3, 1'b0, 32'h0);
        vecs[6]  = mk(CLS_IT, 1, 0, 0, 0, 0, -2048, 1'b1, 32'h80000093);
        vecs[7]  = mk(CLS_IT, 1, 0, 0, 0, 0, 2048, 1'b0, 32'h0);
        vecs[8]  = mk(CLS_BEQ, 0, 0, 0, 5, 0, 4094, 1'b1, 32'h7E000FE3);
        vecs[9]  = mk(3'd6, 1, 1, 1, 0, 0, 0, 1'b0, 32'h0);
        vecs[10] = mk(CLS_BEQ, 0, 0, 0, 0, 0, -4096, 1'b1, 32'h80000063);
        vecs[11] = mk(CLS_SW, 0, 3, 4, 0, 0, -2048, 1'b1, 32'h8041A023);
        vecs[12] = mk(CLS_LW, 1, 1, 0, 0, 0, -2049, 1'b0, 32'h0);
        vecs[13] = mk(CLS_BEQ, 0, 1, 1, 0, 0, 4096, 1'b0, 32'h0);
        vecs[14] = mk(CLS_R, 31, 31, 31, 7, 7'h7F, 64'sh8000_0000_0000_0000, 1'b1, 32'hFFFFFFB3);
        vecs[15] = mk(CLS_SW, 0, 0, 0, 0, 0, IMM_I_MAX + 1, 1'b0, 32'h0);

        rst_n = 1'b0; in_valid = 1'b0; mem_ready = 1'b1; addr_load = 1'b0;
        addr_base = '0; err_clr = 1'b0;
        drive(vecs[0]);
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Vector table, each request pushed on its own.
        exp_ptr = '0;
        n_illegal = 0;
        for (int i = 0; i < 16; i++) begin
            send_one(vecs[i], exp_ptr, $sformatf("vec%0d", i));
            if (vecs[i].legal) exp_ptr = exp_ptr + 12'd4;
            else n_illegal++;
        end
        chk("tbl_err", 64'(err), 64'd1);
        chk("tbl_err_count", 64'(err_count), 64'(n_illegal));
        err_clr = 1'b1; idle(1); err_clr = 1'b0; idle(1);
        chk("clr_err", 64'(err), 64'd0);
        chk("clr_err_count", 64'(err_count), 64'd0);

        // Back-pressure: 4 R words against a memory stalled for 3 cycles.
        addr_load = 1'b1; addr_base = 12'h000; idle(1); addr_load = 1'b0;
        wq_addr.delete(); wq_data.delete(); wq_imm.delete();
        k = 0;
        hold_data = '0; hold_addr = '0;
        for (int c = 0; c < 20 && wq_data.size() < 4; c++) begin
            mem_ready = (c >= 3);
            in_valid  = (k < 4);
            drive(mk(CLS_R, k + 1, k, k + 2, 0, 0, 0, 1'b1, 32'h0));
            obs();
            if (c == 2) begin
                chk("bp_accepts", 64'(k), 64'd2);
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                chk("bp_mem_valid", 64'(mem_valid), 64'd1);
                hold_data = mem_wdata;
                hold_addr = mem_addr;
            end
            if (c == 3) begin
                chk("bp_hold_data", 64'(mem_wdata), 64'(hold_data));
                chk("bp_hold_addr", 64'(mem_addr), 64'(hold_addr));
            end
            if (accepted) k++;
            @(negedge clk);
        end
        in_valid = 1'b0; mem_ready = 1'b1;
        chk("bp_nwords", 64'(wq_data.size()), 64'd4);
        for (int i = 0; i < 4 && i < wq_data.size(); i++) begin
            chk($sformatf("bp_addr%0d", i), 64'(wq_addr[i]), 64'(4 * i));
            chk($sformatf("bp_data%0d", i), 64'(wq_data[i]), 64'(exp_r(i + 1, i, i + 2)));
        end

        // Pointer load near the top of the space, then wrap.
        addr_load = 1'b1; addr_base = 12'hFFE; idle(1); addr_load = 1'b0;
        send_one(mk(CLS_R, 1, 2, 3, 0, 0, 0, 1'b1, exp_r(1, 2, 3)), 12'hFFC, "load_ffc");
        send_one(mk(CLS_R, 4, 5, 6, 0, 0, 0, 1'b1, exp_r(4, 5, 6)), 12'h000, "wrap");

        // Load in the same cycle a word enters stage 2.
        wq_addr.delete(); wq_data.delete(); wq_imm.delete();
        drive(mk(CLS_R, 7, 8, 9, 0, 0, 0, 1'b1, 32'h0));
        in_valid = 1'b1;
        obs();
        chk("coinc_accept", 64'(accepted), 64'd1);
        @(negedge clk);
        in_valid = 1'b0; addr_load = 1'b1; addr_base = 12'h100;
        obs();
        @(negedge clk);
        addr_load = 1'b0;
        idle(3);
        chk("coinc_nwords", 64'(wq_addr.size()), 64'd1);
        if (wq_addr.size() > 0) chk("coinc_old_addr", 64'(wq_addr[0]), 64'h004);
        send_one(mk(CLS_R, 10, 11, 12, 0, 0, 0, 1'b1, exp_r(10, 11, 12)), 12'h100, "after_load");

        // Error counter saturation.
        drive(mk(3'd7, 0, 0, 0, 0, 0, 0, 1'b0, 32'h0));
        in_valid = 1'b1;
        idle(260);
        in_valid = 1'b0;
        idle(3);
        chk("sat_err", 64'(err), 64'd1);
        chk("sat_err_count", 64'(err_count), 64'd255);
        err_clr = 1'b1; idle(1); err_clr = 1'b0; idle(1);
        chk("sat_clr_count", 64'(err_count), 64'd0);

        // A new error arriving with err_clr wins.
        send_one(mk(3'd5, 0, 0, 0, 0, 0, 0, 1'b0, 32'h0), 12'h000, "pre_err");
        chk("pre_err_count", 64'(err_count), 64'd1);
        drive(mk(3'd5, 0, 0, 0, 0, 0, 0, 1'b0, 32'h0));
        in_valid = 1'b1;
        obs();
        chk("clrwin_accept", 64'(accepted), 64'd1);
        @(negedge clk);
        in_valid = 1'b0; err_clr = 1'b1;
        obs();
        @(negedge clk);
        err_clr = 1'b0;
        idle(1);
        chk("clrwin_err", 64'(err), 64'd1);
        chk("clrwin_err_count", 64'(err_count), 64'd1);

        // Reset with both stages full.
        mem_ready = 1'b0;
        drive(mk(CLS_R, 2, 2, 2, 0, 0, 0, 1'b1, 32'h0));
        in_valid = 1'b1;
        k = 0;
        for (int c = 0; c < 6 && k < 2; c++) begin
            obs();
            if (accepted) k++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        obs();
        chk("full_mem_valid", 64'(mem_valid), 64'd1);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("async_mem_valid", 64'(mem_valid), 64'd0);
        chk("async_in_ready", 64'(in_ready), 64'd0);
        chk("async_err_count", 64'(err_count), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        send_one(mk(CLS_IT, 5, 6, 0, 0, 0, -1, 1'b1, 32'hFFF30293), 12'h000, "post_reset");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
